// File: rtl/marchc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : marchc_sequencer
//  Purpose  : Address/cycle sequencer and SRAM datapath for a March C test.
//             Decodes the controller's element enables, sweeps the address
//             range up or down with a per-address cycle counter, issues the
//             read/write strobes of each element, compares read data against
//             the expected background and keeps a sticky pass/fail result
//             with the first failing address.
//  Ports    : clk, rst          - clock (rising edge), async active-high reset
//             start, en1..en5   - one-hot element enables M0..M5 (priority
//                                 start > en1 > ... > en5 if several are high)
//             finish            - controller test-complete flag
//             address, counter  - sweep position fed back to the controller
//             mem_cs/we/addr/wdata, mem_rdata - SRAM interface
//             elem_done         - element sweep finished and holding
//             fail, fail_addr   - sticky mismatch flag and first bad address
//  Revision : 1.0 - initial release
// ============================================================================
module marchc_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  en1,
    input  logic                  en2,
    input  logic                  en3,
    input  logic                  en4,
    input  logic                  en5,
    input  logic                  finish,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [3:0]            counter,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  elem_done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    typedef enum logic [2:0] {
        MODE_NONE = 3'd0,
        MODE_M0   = 3'd1,
        MODE_M1   = 3'd2,
        MODE_M2   = 3'd3,
        MODE_M3   = 3'd4,
        MODE_M4   = 3'd5,
        MODE_M5   = 3'd6
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONES = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONES = '1;

    function automatic logic is_down(input mode_t m);
        return (m == MODE_M3) || (m == MODE_M4);
    endfunction

    mode_t                 dec_mode;
    mode_t                 mode_q, mode_d;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            last_cnt;
    logic [ADDR_WIDTH-1:0] final_addr;

    logic                  op_cs, op_we, rd_req;
    logic [DATA_WIDTH-1:0] op_wdata, rd_exp;

    logic                  pipe_vld_q  [RD_LAT];
    logic [DATA_WIDTH-1:0] pipe_exp_q  [RD_LAT];
    logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LAT];
    logic                  mismatch, fail_clr;
    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;

    // finish has no action here: the result simply stays readable until the
    // next start, so the flag is only observed, never acted upon.
    logic unused_finish;
    assign unused_finish = finish;

    always_comb begin
        dec_mode = MODE_NONE;
        if (start)    dec_mode = MODE_M0;
        else if (en1) dec_mode = MODE_M1;
        else if (en2) dec_mode = MODE_M2;
        else if (en3) dec_mode = MODE_M3;
        else if (en4) dec_mode = MODE_M4;
        else if (en5) dec_mode = MODE_M5;
    end

    assign last_cnt   = ((mode_q == MODE_M0) || (mode_q == MODE_M5)) ? 4'd4 : 4'd8;
    assign final_addr = is_down(mode_q) ? '0 : ADDR_ONES;

    // Sweep control
    always_comb begin
        mode_d  = mode_q;
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (dec_mode == MODE_NONE) begin
            mode_d  = MODE_NONE;
            state_d = ST_IDLE;
        end else if (dec_mode != mode_q) begin
            mode_d  = dec_mode;
            state_d = ST_RUN;
            cnt_d   = 4'd0;
            addr_d  = is_down(dec_mode) ? ADDR_ONES : '0;
        end else if (state_q == ST_RUN) begin
            if (cnt_q == last_cnt) begin
                // Stop on the final cell instead of wrapping so the
                // controller sees a stable end-of-element position.
                if (addr_q == final_addr) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d  = 4'd0;
                    addr_d = is_down(mode_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Memory operation decode from registered sweep position
    always_comb begin
        op_cs    = 1'b0;
        op_we    = 1'b0;
        op_wdata = '0;
        rd_exp   = '0;
        if (state_q == ST_RUN) begin
            if (cnt_q == 4'd1) begin
                op_cs = 1'b1;
                case (mode_q)
                    MODE_M0:          op_we  = 1'b1;
                    MODE_M2, MODE_M4: rd_exp = DATA_ONES;
                    default:          rd_exp = '0;
                endcase
            end else if ((cnt_q == 4'd5) && (mode_q != MODE_M0) && (mode_q != MODE_M5)
                         && (mode_q != MODE_NONE)) begin
                op_cs    = 1'b1;
                op_we    = 1'b1;
                op_wdata = ((mode_q == MODE_M1) || (mode_q == MODE_M3)) ? DATA_ONES : '0;
            end
        end
    end

    assign rd_req = op_cs & ~op_we;

    // The compare pipe keeps shifting regardless of the sweep state so a read
    // issued just before a mode change still gets checked.
    assign mismatch = pipe_vld_q[RD_LAT-1] && (mem_rdata != pipe_exp_q[RD_LAT-1]);
    assign fail_clr = (dec_mode == MODE_M0) && (mode_q != MODE_M0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_NONE;
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= 4'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_exp_q[i]  <= '0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;

            pipe_vld_q[0]  <= rd_req;
            pipe_exp_q[0]  <= rd_exp;
            pipe_addr_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end

            // A new test run starts with a clean result.
            if (fail_clr) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
            end else if (mismatch) begin
                fail_q <= 1'b1;
                if (!fail_q) begin
                    fail_addr_q <= pipe_addr_q[RD_LAT-1];
                end
            end
        end
    end

    assign address   = addr_q;
    assign counter   = cnt_q;
    assign mem_addr  = addr_q;
    assign mem_cs    = op_cs;
    assign mem_we    = op_we;
    assign mem_wdata = op_wdata;
    assign elem_done = (state_q == ST_HOLD);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;

endmodule
`default_nettype wire
